// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int STALL_W_DEF   = 16;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    // Offsets 1..N so 'last' itself is the lowest priority candidate.
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int STALL_W   = STALL_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fifo_full,
  output logic                      fifo_write,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic                      busy,
  output logic [STALL_W-1:0]        stall_cnt
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int BW = idx_w(MAX_BURST);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] owner, owner_nxt, last, last_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, pick_oh;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          in_burst, own_req, transfer, stalled, release_now;
  logic [DATA_W-1:0] lane_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_data[g] = wdata[g*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .last   (last),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  assign in_burst    = (state == BURST);
  assign own_req     = req[owner];
  assign transfer    = in_burst & own_req & ~fifo_full;
  assign stalled     = in_burst & own_req & fifo_full;
  // Owner dropping req or finishing its last beat both hand the port back.
  assign release_now = in_burst & (~own_req | (transfer & (beat_cnt == LAST_BEAT)));

  assign fifo_write   = transfer & ~rst;
  assign fifo_data_in = in_burst ? lane_data[owner] : '0;
  assign busy         = in_burst;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    last_nxt  = last;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = BURST;
          gnt_nxt   = pick_oh;
          owner_nxt = pick_idx;
          beat_nxt  = '0;
        end
      end
      BURST: begin
        if (release_now) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          last_nxt  = owner;
        end else if (transfer) begin
          beat_nxt = beat_cnt + BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      last      <= IW'(NUM_REQ - 1);
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_nxt;
      if (stalled && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_no_full_write: assert property (@(posedge clk) disable iff (rst) fifo_write |-> !fifo_full);
  a_write_owned: assert property (@(posedge clk) disable iff (rst) fifo_write |-> |(gnt & req));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter; producers are word queues.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int SW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  wdata;
  logic [NR-1:0]     gnt;
  logic              fifo_full;
  logic              fifo_write;
  logic [DW-1:0]     fifo_data_in;
  logic              busy;
  logic [SW-1:0]     stall_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB), .STALL_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .wdata        (wdata),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .busy         (busy),
    .stall_cnt    (stall_cnt)
  );

  typedef struct packed {logic [3:0] id; logic [7:0] d;} exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] wd [NR][16];
  int nw [NR];
  int pos [NR];
  int m_last = NR - 1;
  int full_cycles = 0;
  int full_pct = 0;
  logic [NR-1:0] s_gnt = '0;
  logic s_write = 1'b0, s_full = 1'b0, s_busy = 1'b0;
  logic [NR-1:0] prev_gnt = '0;
  bit want_gnt = 1'b0;

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: round-robin over producers with words left, MB words per grant.
  task automatic build_expected();
    int rem [NR];
    int p [NR];
    int l;
    exp_t e;
    l = m_last;
    for (int i = 0; i < NR; i++) begin rem[i] = nw[i] - pos[i]; p[i] = pos[i]; end
    for (int guard = 0; guard < 200; guard++) begin
      int j;
      j = -1;
      for (int k = 1; k <= NR; k++)
        if (j < 0 && rem[(l + k) % NR] > 0) j = (l + k) % NR;
      if (j < 0) break;
      for (int b = 0; b < MB && rem[j] > 0; b++) begin
        e.id = 4'(j);
        e.d  = wd[j][p[j]];
        exp_q.push_back(e);
        p[j]++;
        rem[j]--;
      end
      l = j;
    end
    m_last = l;
  endtask

  task automatic load(input int i, input int n, input bit seq, input logic [7:0] base);
    nw[i]  = n;
    pos[i] = 0;
    for (int k = 0; k < 16; k++) wd[i][k] = seq ? base + 8'(k) : 8'($urandom);
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      req[i] = (pos[i] < nw[i]);
      wdata[i*DW +: DW] = (pos[i] < nw[i]) ? wd[i][pos[i]] : 8'h00;
    end
    if (full_cycles > 0) begin
      fifo_full = 1'b1;
      full_cycles--;
    end else begin
      fifo_full = (full_pct > 0) && ($urandom_range(99) < full_pct);
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_gnt = gnt; s_write = fifo_write; s_full = fifo_full; s_busy = busy;
    @(posedge clk);
    #1;
    if (s_write)
      for (int i = 0; i < NR; i++) if (s_gnt[i]) pos[i]++;
    apply();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NR; i++) if (pos[i] < nw[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((!all_done() || exp_q.size() != 0) && c < 600) begin step(); c++; end
    chk({tag, "_timeout"}, (c >= 600), 0);
    repeat (3) step();
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_idle"}, s_busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    full_cycles = 0;
    step();
    rst = 1'b0;
    m_last = NR - 1;
    exp_q.delete();
  endtask

  // Monitor: every write must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      want_gnt = 1'b0;
      prev_gnt = '0;
    end else begin
      n_chk++;
      if (!$onehot0(gnt)) begin n_fail++; $display("FAIL gnt_onehot: gnt=%b", gnt); end
      if (fifo_write) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_write: data=%h gnt=%b with nothing expected", fifo_data_in, gnt);
        end else begin
          e = exp_q.pop_front();
          if (fifo_data_in !== e.d || gnt !== (NR'(1) << e.id)) begin
            n_fail++;
            $display("FAIL write_data: got data=%h gnt=%b expected data=%h producer=%0d",
                     fifo_data_in, gnt, e.d, e.id);
          end
        end
        n_chk++;
        if (fifo_full) begin n_fail++; $display("FAIL write_full: write=1 while fifo_full=1"); end
      end
      if (gnt == '0) begin
        n_chk++;
        if (fifo_write !== 1'b0 || fifo_data_in !== '0) begin
          n_fail++;
          $display("FAIL idle_out: write=%b data=%h expected 0/00", fifo_write, fifo_data_in);
        end
      end
      if (want_gnt) begin
        n_chk++;
        if (gnt == '0) begin n_fail++; $display("FAIL bubble: gnt=0 for 2 cycles with req=%b", req); end
      end
      want_gnt = (prev_gnt != '0) && (gnt == '0) && (req != '0);
      prev_gnt = gnt;
    end
  end

  initial begin
    int c, stalls;
    bit armed;
    rst = 1'b1;
    req = '1;
    wdata = $urandom;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin nw[i] = 0; pos[i] = 0; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_write", fifo_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_last = NR - 1;
    apply();

    // Lone producer 2, six words: one-cycle grant latency, then 4 + 2 beats.
    load(2, 6, 1'b1, 8'hA0);
    build_expected();
    apply();
    step(); chk("lat_idle", s_gnt, 0);
    step(); chk("lat_gnt", s_gnt, 4'b0100);
    drain("p2");

    // All four requesting: rotation 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 8, 1'b1, 8'(8'h10 * (i + 1)));
    build_expected();
    apply();
    drain("allf");

    // Reset in the middle of producer 3's burst.
    for (int i = 0; i < NR; i++) load(i, 8, 1'b0, 8'h00);
    build_expected();
    apply();
    c = 0;
    while (!(s_gnt == 4'b1000 && s_write) && c < 400) begin step(); c++; end
    chk("mid_reach_p3", (c >= 400), 0);
    rst = 1'b1;
    exp_q.delete();
    step(); chk("mid_rst_write", s_write, 0);
    step(); chk("mid_rst_gnt", s_gnt, 0);
    rst = 1'b0;
    m_last = NR - 1;
    build_expected();
    step(); step(); chk("mid_first_gnt", s_gnt, 4'b0001);
    drain("midrst");

    // Full for 3 cycles after the second beat of producer 0.
    do_reset();
    load(0, 4, 1'b1, 8'h50);
    build_expected();
    apply();
    c = 0; stalls = 0; armed = 1'b0;
    while (pos[0] < nw[0] && c < 100) begin
      step(); c++;
      if (s_full) begin
        stalls++;
        chk("stall_gnt", s_gnt, 4'b0001);
        chk("stall_busy", s_busy, 1);
      end
      if (s_write && !armed) begin armed = 1'b1; full_cycles = 3; end
    end
    drain("stall");
    @(negedge clk);
    chk("stall_cnt", stall_cnt, 3);

    // Producer 0 drops after 2 beats while producer 1 waits.
    do_reset();
    load(0, 2, 1'b1, 8'hC0);
    load(1, 3, 1'b1, 8'hD0);
    build_expected();
    apply();
    drain("drop");

    // Random word counts and random fifo_full back-pressure.
    full_pct = 30;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NR; i++) load(i, int'($urandom_range(0, 10)), 1'b0, 8'h00);
      build_expected();
      apply();
      drain("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
